// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit word load/store onto a 16-bit off-chip
// SRAM bus as two halfword accesses (low half first), each held for
// WAIT_CYCLES clocks. ready drops while a word is in flight so the pipeline
// freezes until the transfer has finished.
module sram_controller #(
    parameter int WAIT_CYCLES = 3,
    parameter int MEM_BASE    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        SRAM_WE_N,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ
);

    // A single-cycle access still needs a one-bit counter to stay legal.
    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]      BASE     = 32'(MEM_BASE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Transfer context captured when a request is accepted.
    logic             op_write;
    logic [16:0]      hw_idx;
    logic [31:0]      wd_q;

    logic             request;
    logic             accept;
    logic             capture_lo;
    logic             capture_hi;
    logic [31:0]      offset;
    logic             unused_bits;

    logic             dq_oe;
    logic [15:0]      dq_out;

    assign request = wr_en | rd_en;

    // The halfword index is derived once at acceptance so the SRAM address
    // pins come straight from a register and cannot glitch.
    assign offset      = address - BASE;
    assign unused_bits = ^{offset[31:19], offset[1:0]};

    // The bus is driven only while a write access owns it.
    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

    // State and wait-counter register; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Latch the operation, halfword index and store data on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write <= 1'b0;
            hw_idx   <= '0;
            wd_q     <= '0;
        end else if (accept) begin
            op_write <= wr_en;
            hw_idx   <= offset[18:2];
            wd_q     <= write_data;
        end
    end

    // Load result: each half is captured on the last edge of its access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else begin
            if (capture_lo) begin
                read_data[15:0] <= SRAM_DQ;
            end
            if (capture_hi) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // Next-state, wait counting, acceptance and the pipeline ready flag.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture_lo = 1'b0;
        capture_hi = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = ~request;
                if (request) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = ACC_LO;
                end
            end
            ACC_LO: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = ACC_HI;
                    capture_lo = ~op_write;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ACC_HI: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = DONE;
                    capture_hi = ~op_write;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SRAM pin values depend only on registered state and latched context.
    always_comb begin
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            ACC_LO: begin
                SRAM_ADDR = {hw_idx, 1'b0};
                if (op_write) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = wd_q[15:0];
                end
            end
            ACC_HI: begin
                SRAM_ADDR = {hw_idx, 1'b1};
                if (op_write) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = wd_q[31:16];
                end
            end
            default: begin
                SRAM_WE_N = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller with a small
// asynchronous SRAM model (drives the bus whenever write-enable is high).
// A second instance with single-cycle accesses covers back-to-back reads.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_we_n;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;

    logic        wr_en1;
    logic        rd_en1;
    logic [31:0] address1;
    logic [31:0] write_data1;
    logic [31:0] read_data1;
    logic        ready1;
    logic        sram_we_n1;
    logic [17:0] sram_addr1;
    wire  [15:0] sram_dq1;

    logic [15:0] mem  [0:255];
    logic [15:0] mem1 [0:255];
    logic        mem_init;

    int          checks   = 0;
    int          failures = 0;
    int          ready_low;
    int          we_low;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(3), .MEM_BASE(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq)
    );

    sram_controller #(.WAIT_CYCLES(1), .MEM_BASE(1024)) dut_w1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en1),
        .rd_en      (rd_en1),
        .address    (address1),
        .write_data (write_data1),
        .read_data  (read_data1),
        .ready      (ready1),
        .SRAM_WE_N  (sram_we_n1),
        .SRAM_ADDR  (sram_addr1),
        .SRAM_DQ    (sram_dq1)
    );

    assign sram_dq  = sram_we_n  ? mem[sram_addr[7:0]]   : 16'bz;
    assign sram_dq1 = sram_we_n1 ? mem1[sram_addr1[7:0]] : 16'bz;

    // SRAM models: cleared/preloaded on request, otherwise written while WE_N low.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= 16'h0000;
                mem1[i] <= {4{4'(i + 1)}};
            end
        end else begin
            if (!sram_we_n) begin
                mem[sram_addr[7:0]] <= sram_dq;
            end
            if (!sram_we_n1) begin
                mem1[sram_addr1[7:0]] <= sram_dq1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wd);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wd;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in cycle 0, swaps in stale values after acceptance,
    // and returns in the first ready-high cycle (DONE) with low-cycle counts.
    task automatic doTransfer(input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] stale_addr, input logic [31:0] stale_wd,
                              output int rl, output int wl);
        int guard;
        applyStimulus(wr, rd, addr, wd);
        #1;
        rl    = 0;
        wl    = 0;
        guard = 0;
        while (!ready && guard < 40) begin
            rl++;
            if (!sram_we_n) wl++;
            stepCycle();
            if (guard == 0) applyStimulus(1'b0, 1'b0, stale_addr, stale_wd);
            guard++;
        end
        if (guard >= 40) checkOutput("transfer_timeout", 32'(guard), 32'd0);
    endtask

    // Run-away guard so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        wr_en1      = 1'b0;
        rd_en1      = 1'b0;
        address1    = 32'd0;
        write_data1 = 32'd0;
        mem_init    = 1'b1;
        #2 rst = 1'b0;
        repeat (2) stepCycle();
        mem_init = 1'b0;

        checkOutput("rst_ready",     32'(ready),     32'd1);
        checkOutput("rst_we_n",      32'(sram_we_n), 32'd1);
        checkOutput("rst_addr",      32'(sram_addr), 32'd0);
        checkOutput("rst_read_data", read_data,      32'd0);
        rst = 1'b1;
        stepCycle();
        checkOutput("idle_ready", 32'(ready), 32'd1);

        // Word write of 0xDEADBEEF at the base address.
        doTransfer(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 32'd0, ready_low, we_low);
        checkOutput("wr_ready_low", 32'(ready_low), 32'd7);
        checkOutput("wr_we_low",    32'(we_low),    32'd6);
        checkOutput("wr_done_we_n", 32'(sram_we_n), 32'd1);
        stepCycle();
        checkOutput("wr_idle_ready", 32'(ready),  32'd1);
        checkOutput("wr_mem0",       32'(mem[0]), 32'h0000BEEF);
        checkOutput("wr_mem1",       32'(mem[1]), 32'h0000DEAD);
        checkOutput("wr_read_data",  read_data,   32'd0);

        // Read the same word back.
        doTransfer(1'b0, 1'b1, 32'd1024, 32'd0, 32'd0, 32'd0, ready_low, we_low);
        checkOutput("rd_ready_low", 32'(ready_low), 32'd7);
        checkOutput("rd_we_low",    32'(we_low),    32'd0);
        checkOutput("rd_data",      read_data,      32'hDEADBEEF);
        stepCycle();

        // Addressing: low address bits are ignored.
        doTransfer(1'b1, 1'b0, 32'd1036, 32'h12345678, 32'd0, 32'd0, ready_low, we_low);
        stepCycle();
        checkOutput("addr_mem6", 32'(mem[6]), 32'h00005678);
        checkOutput("addr_mem7", 32'(mem[7]), 32'h00001234);
        doTransfer(1'b1, 1'b0, 32'd1037, 32'h0BADF00D, 32'd0, 32'd0, ready_low, we_low);
        stepCycle();
        checkOutput("addr_b_mem6", 32'(mem[6]), 32'h0000F00D);
        checkOutput("addr_b_mem7", 32'(mem[7]), 32'h00000BAD);
        checkOutput("addr_b_mem5", 32'(mem[5]), 32'h00000000);
        checkOutput("addr_b_mem8", 32'(mem[8]), 32'h00000000);

        // Both requests high: write wins; inputs changed in ACC_LO are ignored.
        doTransfer(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'd1040, 32'h11112222, ready_low, we_low);
        checkOutput("sim_we_low", 32'(we_low), 32'd6);
        stepCycle();
        checkOutput("sim_mem2",      32'(mem[2]), 32'h0000F00D);
        checkOutput("sim_mem3",      32'(mem[3]), 32'h0000CAFE);
        checkOutput("sim_mem8",      32'(mem[8]), 32'h00000000);
        checkOutput("sim_mem9",      32'(mem[9]), 32'h00000000);
        checkOutput("sim_read_data", read_data,   32'hDEADBEEF);

        // Reset in the middle of the high-half write access.
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h55AA33CC);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) stepCycle();
        checkOutput("mid_addr", 32'(sram_addr), 32'd1);
        checkOutput("mid_we_n", 32'(sram_we_n), 32'd0);
        checkOutput("mid_dq",   32'(sram_dq),   32'h000055AA);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_we_n",      32'(sram_we_n), 32'd1);
        checkOutput("abort_addr",      32'(sram_addr), 32'd0);
        checkOutput("abort_dq",        32'(sram_dq),   32'h000033CC);
        checkOutput("abort_read_data", read_data,      32'd0);
        #2 rst = 1'b1;
        stepCycle();
        checkOutput("abort_ready", 32'(ready), 32'd1);

        // Back-to-back single-cycle reads with the request held.
        rd_en1   = 1'b1;
        address1 = 32'd1024;
        #1;
        for (int c = 0; c < 9; c++) begin
            checkOutput($sformatf("b2b_ready_c%0d", c), 32'(ready1),
                        (c == 3 || c == 7 || c == 8) ? 32'd1 : 32'd0);
            if (c == 2) checkOutput("b2b_addr_hi", 32'(sram_addr1), 32'd1);
            if (c == 3) begin
                checkOutput("b2b_word0", read_data1, 32'h22221111);
                address1 = 32'd1028;
            end
            if (c == 7) begin
                checkOutput("b2b_word1", read_data1, 32'h44443333);
                rd_en1 = 1'b0;
            end
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage bridge between the ARM pipeline's 32-bit data-memory request (word-addressed from base 1024) and the 16-bit off-chip SRAM bus. It accepts one load or store at a time and splits it into two halfword SRAM accesses, low half first. It drives SRAM address, write-enable and the bidirectional data bus. It deasserts `ready` while busy so the pipeline freezes until the word transfer completes.

## Interface
- `WAIT_CYCLES`, default 3: clock cycles each halfword access is held on the SRAM bus; must be ≥1.
- `MEM_BASE`, default 1024: pipeline byte address mapped to SRAM halfword 0.

- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: store request.
- `rd_en` in 1: load request.
- `address` in 32: byte address; bits [1:0] ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: high when no transfer is pending; pipeline freeze = ~ready.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_DQ` inout 16: SRAM data bus.

## Operation
- States: IDLE, ACC_LO, ACC_HI, DONE. 2-bit state register plus a wait counter `cnt` of width clog2(WAIT_CYCLES).
- IDLE, no request: `ready`=1, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z.
- IDLE, request present: `ready`=0 combinationally.
  - At the next edge, latch op (write if `wr_en`, else read), `address` and `write_data`.
  - Go to ACC_LO with `cnt`=0.
- If `wr_en` and `rd_en` are both high, write wins.
- Halfword index = (latched address − MEM_BASE)[18:2], 17 bits. Low half uses `SRAM_ADDR`={idx,0}; high half uses {idx,1}. Wrap modulo 2^18; no range check.
- ACC_LO / ACC_HI:
  - `SRAM_ADDR` = low/high halfword address.
  - Write: `SRAM_WE_N`=0; `SRAM_DQ` driven with `wd[15:0]` / `wd[31:16]`.
  - Read: `SRAM_WE_N`=1; `SRAM_DQ`=Z.
  - `cnt` increments each cycle. When `cnt`==WAIT_CYCLES−1, reset `cnt` and advance: ACC_LO→ACC_HI, ACC_HI→DONE.
  - On that same final edge of a read, capture `SRAM_DQ` into `read_data[15:0]` (ACC_LO) or `read_data[31:16]` (ACC_HI).
- DONE: `ready`=1 for exactly one cycle, `SRAM_WE_N`=1, `SRAM_DQ`=Z. Always goes to IDLE. Requests seen in DONE are not accepted; they are taken from IDLE.
- `read_data` holds its value until the next read overwrites it. Writes never change it.
- `SRAM_DQ` is driven only while state ∈ {ACC_LO, ACC_HI} and op=write. It is never driven with `SRAM_WE_N`=1.
- Input changes after acceptance have no effect until the next IDLE.

## Timing
- Reset (asserted `rst`=0, async):
  - state=IDLE, `cnt`=0, `read_data`=0, latched registers=0.
  - `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z.
  - `ready` follows the IDLE rule.
- Reset mid-transfer aborts immediately and the bus is released. A partial write (low half only) may remain in SRAM. That is accepted behaviour.
- Latency, counting the IDLE cycle with a request as cycle 0:
  - ACC_LO occupies cycles 1..W; ACC_HI occupies W+1..2W; DONE is cycle 2W+1.
  - `ready` is low for 2W+1 cycles.
  - `read_data` is complete and valid in DONE.
- SRAM read access time must be < W·Tclk: address is stable from the state-entry edge to the capture edge.
- Back-to-back requests: the next transfer is accepted at the earliest on the edge leaving the IDLE that follows DONE. Minimum 2W+2 cycles per word.
- All outputs except `ready` are pure functions of registered state, so they are glitch-free at the SRAM pins.

## Test plan
- **Reset:** hold `rst`=0 mid-ACC_HI write, W=3 -> `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0, `read_data`=0 within the same cycle. After release with no request: `ready`=1.
- **Write:** W=3, `wr_en`=1, `address`=1024, `write_data`=0xDEADBEEF -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD. `ready` low 7 cycles, high in cycle 7. `SRAM_WE_N`=0 exactly 6 cycles.
- **Read-back:** after the write above, `rd_en`=1, `address`=1024 -> `read_data`=0xDEADBEEF in DONE. `SRAM_DQ` never driven by the controller.
- **Addressing:** write 0x12345678 at `address`=1036 -> SRAM[6]=0x5678, SRAM[7]=0x1234. Repeat with `address`=1037 -> same halfwords (bits [1:0] ignored).
- **Simultaneous / stale inputs:** `wr_en`=`rd_en`=1 at 1028 with 0xCAFEF00D -> write performed, `read_data` unchanged. Changing `address`/`write_data` during ACC_LO -> SRAM[2]=0xF00D, SRAM[3]=0xCAFE.
- **Back-to-back / W=1:** reads from 1024 then 1028, requests held continuously -> `ready` pulses once per word, 4 cycles apart (2W+2). Second `read_data` is the word at halfwords 2/3.
